// File: rtl/game_session_ctrl_if.sv
// Board/game-core side signals of the session controller.
// The controller connects through the slave modport; the board/core side uses master.
interface game_session_ctrl_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int LIVES_W     = 2
);
    logic                           start_key;
    logic                           pause_key;
    logic                           gameover;
    logic [NUM_PLAYERS-1:0]         life_lost;
    logic                           reset_is_on;
    logic                           playing;
    logic                           paused;
    logic                           over;
    logic [1:0]                     state;
    logic [NUM_PLAYERS*LIVES_W-1:0] lives;
    logic [NUM_PLAYERS-1:0]         winner;

    modport master (
        output start_key, pause_key, gameover, life_lost,
        input  reset_is_on, playing, paused, over, state, lives, winner
    );

    modport slave (
        input  start_key, pause_key, gameover, life_lost,
        output reset_is_on, playing, paused, over, state, lives, winner
    );
endinterface

// File: rtl/game_session_ctrl.sv
// Game session FSM: debounced start/pause keys, per-player lives, session end detection
// and the game-core reset / status flags.
module game_session_ctrl #(
    parameter int NUM_PLAYERS          = 2,
    parameter int LIVES                = 3,
    parameter int LIVES_W              = 2,
    parameter int DEBOUNCE_CYCLES      = 16,
    parameter int GAMEOVER_HOLD_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    game_session_ctrl_if.slave  bus
);
    localparam int DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W    = $clog2(GAMEOVER_HOLD_CYCLES + 1);
    localparam int CNT_W     = $clog2(NUM_PLAYERS + 1);
    localparam int MIN_ALIVE = (NUM_PLAYERS < 2) ? NUM_PLAYERS : 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PLAYING  = 2'd1,
        ST_PAUSED   = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_t;

    state_t              r_state;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [NUM_PLAYERS-1:0] r_winner;
    logic [LIVES_W-1:0]  r_lives     [NUM_PLAYERS];
    logic [LIVES_W-1:0]  w_lives_dec [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] w_alive_cur;
    logic [NUM_PLAYERS-1:0] w_alive_dec;
    logic [CNT_W-1:0]    w_alive_cnt;
    logic                w_end_cond;
    logic                w_hold_done;
    logic [1:0]          w_key_raw;
    logic [1:0]          w_key_rise;
    logic                w_start_rise;
    logic                w_pause_rise;

    assign w_key_raw    = {bus.pause_key, bus.start_key};
    assign w_start_rise = w_key_rise[0];
    assign w_pause_rise = w_key_rise[1];

    genvar gi;

    // Per key: 2-flop synchronizer, stability counter, rising-edge detect.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            logic            r_meta;
            logic            r_sync;
            logic            r_db;
            logic            r_db_d;
            logic [DB_W-1:0] r_cnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_meta <= 1'b0;
                    r_sync <= 1'b0;
                    r_db   <= 1'b0;
                    r_db_d <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_meta <= w_key_raw[gi];
                    r_sync <= r_meta;
                    r_db_d <= r_db;
                    if (r_sync == r_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_db  <= r_sync;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + DB_W'(1);
                    end
                end
            end

            assign w_key_rise[gi] = r_db & ~r_db_d;
        end
    endgenerate

    // Saturating decrement; alive masks before and after this cycle's losses.
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            assign w_lives_dec[gi] = (bus.life_lost[gi] && (r_lives[gi] != '0))
                                   ? r_lives[gi] - LIVES_W'(1) : r_lives[gi];
            assign w_alive_cur[gi] = |r_lives[gi];
            assign w_alive_dec[gi] = |w_lives_dec[gi];
            assign bus.lives[gi*LIVES_W +: LIVES_W] = r_lives[gi];
        end
    endgenerate

    always_comb begin
        w_alive_cnt = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            w_alive_cnt = w_alive_cnt + CNT_W'(w_alive_dec[i]);
        end
    end

    assign w_end_cond  = (w_alive_cnt < CNT_W'(MIN_ALIVE));
    // Counter holds k-1 at the k-th edge after entry, so expiry is reached at HOLD-1.
    assign w_hold_done = (r_hold_cnt >= HOLD_W'(GAMEOVER_HOLD_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_winner   <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                r_lives[i] <= LIVES_W'(LIVES);
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_hold_cnt <= '0;
                    r_winner   <= '0;
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        r_lives[i] <= LIVES_W'(LIVES);
                    end
                    if (w_start_rise) begin
                        r_state <= ST_PLAYING;
                    end
                end
                ST_PLAYING: begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        r_lives[i] <= w_lives_dec[i];
                    end
                    if (bus.gameover || w_end_cond) begin
                        r_state    <= ST_GAMEOVER;
                        r_winner   <= w_alive_dec;
                        r_hold_cnt <= '0;
                    end else if (w_pause_rise) begin
                        r_state <= ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (bus.gameover) begin
                        r_state    <= ST_GAMEOVER;
                        r_winner   <= w_alive_cur;
                        r_hold_cnt <= '0;
                    end else if (w_pause_rise) begin
                        r_state <= ST_PLAYING;
                    end else if (w_start_rise) begin
                        r_state <= ST_IDLE;
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            r_lives[i] <= LIVES_W'(LIVES);
                        end
                    end
                end
                default: begin
                    // Early start presses are dropped, not remembered.
                    if (w_hold_done && w_start_rise) begin
                        r_state    <= ST_PLAYING;
                        r_winner   <= '0;
                        r_hold_cnt <= '0;
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            r_lives[i] <= LIVES_W'(LIVES);
                        end
                    end else if (!w_hold_done) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.state       = r_state;
    assign bus.reset_is_on = (r_state == ST_IDLE) || (r_state == ST_GAMEOVER);
    assign bus.playing     = (r_state == ST_PLAYING);
    assign bus.paused      = (r_state == ST_PAUSED);
    assign bus.over        = (r_state == ST_GAMEOVER);
    assign bus.winner      = r_winner;
endmodule

// File: tb/tb_game_session_ctrl.sv
// Self-checking bench for game_session_ctrl: vector table for lives/end handling plus
// hand-written key, hold-window and async-reset sequences, checked through a scoreboard queue.
module tb_game_session_ctrl;
    localparam int KEY_START = 0;
    localparam int KEY_PAUSE = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    game_session_ctrl_if #(.NUM_PLAYERS(2), .LIVES_W(2)) bus ();

    game_session_ctrl #(
        .NUM_PLAYERS(2), .LIVES(2), .LIVES_W(2),
        .DEBOUNCE_CYCLES(4), .GAMEOVER_HOLD_CYCLES(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string      name;
        logic [1:0] st;
        logic [3:0] lv;
        logic [1:0] win;
    } exp_t;

    typedef struct packed {
        logic       restart;
        logic [1:0] ll;
        logic       go;
        logic [1:0] st;
        logic [3:0] lv;
        logic [1:0] win;
    } vec_t;

    exp_t sb_q[$];
    vec_t vt [8];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic sb_push(input string name, input logic [1:0] st, input logic [3:0] lv,
                           input logic [1:0] win);
        exp_t e;
        e.name = name; e.st = st; e.lv = lv; e.win = win;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty: got no expectation, required one");
        end else begin
            e = sb_q.pop_front();
            chk({e.name, ".state"},   8'(bus.state),       8'(e.st));
            chk({e.name, ".lives"},   8'(bus.lives),       8'(e.lv));
            chk({e.name, ".winner"},  8'(bus.winner),      8'(e.win));
            chk({e.name, ".rst_on"},  8'(bus.reset_is_on), 8'((e.st == 2'd0) || (e.st == 2'd3)));
            chk({e.name, ".playing"}, 8'(bus.playing),     8'(e.st == 2'd1));
            chk({e.name, ".paused"},  8'(bus.paused),      8'(e.st == 2'd2));
            chk({e.name, ".over"},    8'(bus.over),        8'(e.st == 2'd3));
        end
    endtask

    task automatic set_key(input int key, input logic v);
        if (key == KEY_START) bus.start_key = v;
        else bus.pause_key = v;
    endtask

    // Raw rise at a negedge takes effect on the 7th following posedge (2 sync + 4 stable + edge).
    task automatic press(input int key, input logic [1:0] ll, input logic [1:0] pre_st,
                         input logic [1:0] st, input logic [3:0] lv, input logic [1:0] win,
                         input string name);
        set_key(key, 1'b1);
        repeat (6) @(negedge clk);
        chk({name, ".pre_state"}, 8'(bus.state), 8'(pre_st));
        bus.life_lost = ll;
        sb_push(name, st, lv, win);
        @(negedge clk);
        sb_pop();
        bus.life_lost = 2'b00;
    endtask

    task automatic release_key(input int key);
        set_key(key, 1'b0);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{1'b0, 2'b00, 1'b0, 2'd1, 4'b1010, 2'b00};
        vt[1] = '{1'b0, 2'b01, 1'b0, 2'd1, 4'b1001, 2'b00};
        vt[2] = '{1'b0, 2'b01, 1'b0, 2'd3, 4'b1000, 2'b10};
        vt[3] = '{1'b0, 2'b01, 1'b0, 2'd3, 4'b1000, 2'b10};
        vt[4] = '{1'b1, 2'b11, 1'b0, 2'd1, 4'b0101, 2'b00};
        vt[5] = '{1'b0, 2'b11, 1'b0, 2'd3, 4'b0000, 2'b00};
        vt[6] = '{1'b1, 2'b10, 1'b1, 2'd3, 4'b0110, 2'b11};
        vt[7] = '{1'b1, 2'b00, 1'b0, 2'd1, 4'b1010, 2'b00};

        reset = 1'b1;
        bus.start_key = 1'b0;
        bus.pause_key = 1'b0;
        bus.gameover  = 1'b0;
        bus.life_lost = 2'b00;
        repeat (2) @(negedge clk);
        sb_push("reset", 2'd0, 4'b1010, 2'b00);
        sb_pop();
        reset = 1'b0;
        @(negedge clk);

        // Bouncing start key never settles for 4 cycles.
        for (int i = 0; i < 10; i++) begin
            bus.start_key = ~bus.start_key;
            repeat (2) @(negedge clk);
        end
        bus.start_key = 1'b0;
        repeat (10) @(negedge clk);
        sb_push("bounce", 2'd0, 4'b1010, 2'b00);
        sb_pop();

        press(KEY_START, 2'b00, 2'd0, 2'd1, 4'b1010, 2'b00, "clean_start");
        release_key(KEY_START);

        for (int i = 0; i < 8; i++) begin
            if (vt[i].restart) begin
                repeat (2) @(negedge clk);
                press(KEY_START, 2'b00, 2'd3, 2'd1, 4'b1010, 2'b00, $sformatf("restart%0d", i));
                release_key(KEY_START);
            end
            bus.life_lost = vt[i].ll;
            bus.gameover  = vt[i].go;
            sb_push($sformatf("vec%0d", i), vt[i].st, vt[i].lv, vt[i].win);
            @(negedge clk);
            sb_pop();
            bus.life_lost = 2'b00;
            bus.gameover  = 1'b0;
        end

        // Loss on the same edge as the pause rise: decrement applies, state pauses.
        press(KEY_PAUSE, 2'b01, 2'd1, 2'd2, 4'b1001, 2'b00, "pause_with_loss");
        release_key(KEY_PAUSE);
        bus.life_lost = 2'b11;
        sb_push("paused_loss_ignored", 2'd2, 4'b1001, 2'b00);
        @(negedge clk);
        sb_pop();
        bus.life_lost = 2'b00;
        press(KEY_PAUSE, 2'b00, 2'd2, 2'd1, 4'b1001, 2'b00, "resume");
        release_key(KEY_PAUSE);
        press(KEY_PAUSE, 2'b00, 2'd1, 2'd2, 4'b1001, 2'b00, "pause2");
        release_key(KEY_PAUSE);

        // Start rise lands 3 edges after GAMEOVER entry: discarded.
        bus.start_key = 1'b1;
        repeat (3) @(negedge clk);
        bus.gameover = 1'b1;
        sb_push("gameover_paused", 2'd3, 4'b1001, 2'b11);
        @(negedge clk);
        sb_pop();
        bus.gameover = 1'b0;
        repeat (2) @(negedge clk);
        sb_push("early_start", 2'd3, 4'b1001, 2'b11);
        @(negedge clk);
        sb_pop();
        release_key(KEY_START);
        sb_push("not_queued", 2'd3, 4'b1001, 2'b11);
        sb_pop();

        // Rise at entry+7 is still inside the hold window.
        press(KEY_START, 2'b00, 2'd3, 2'd1, 4'b1010, 2'b00, "restart_a");
        release_key(KEY_START);
        bus.gameover = 1'b1;
        sb_push("go_a", 2'd3, 4'b1010, 2'b11);
        @(negedge clk);
        sb_pop();
        bus.gameover = 1'b0;
        press(KEY_START, 2'b00, 2'd3, 2'd3, 4'b1010, 2'b11, "hold_minus1");
        release_key(KEY_START);

        // Rise at entry+8 is the first accepted one.
        press(KEY_START, 2'b00, 2'd3, 2'd1, 4'b1010, 2'b00, "restart_b");
        release_key(KEY_START);
        bus.life_lost = 2'b10;
        bus.gameover  = 1'b1;
        sb_push("go_b", 2'd3, 4'b0110, 2'b11);
        @(negedge clk);
        sb_pop();
        bus.life_lost = 2'b00;
        bus.gameover  = 1'b0;
        @(negedge clk);
        press(KEY_START, 2'b00, 2'd3, 2'd1, 4'b1010, 2'b00, "hold_exact");
        release_key(KEY_START);

        // Async reset in PAUSED with a pause edge still in the debouncer.
        press(KEY_PAUSE, 2'b00, 2'd1, 2'd2, 4'b1010, 2'b00, "pause3");
        release_key(KEY_PAUSE);
        bus.pause_key = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        sb_push("async_reset", 2'd0, 4'b1010, 2'b00);
        sb_pop();
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        sb_push("pending_discarded", 2'd0, 4'b1010, 2'b00);
        sb_pop();
        release_key(KEY_PAUSE);
        press(KEY_START, 2'b00, 2'd0, 2'd1, 4'b1010, 2'b00, "recover_start");
        release_key(KEY_START);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
